// File: rtl/game_state_ctrl.sv
// Purpose: breakout-style game sequencer. It covers the IDLE/SERVE/PLAY/OVER flow, BCD score, lives and serve timing.
// Latency: start is acted on 3 clk after the pin falls; a vsync rise is acted on 1 clk later; all outputs are registered.
// Backpressure: none. Every input is sampled each clk, and events that arrive in states that ignore them are dropped.
//
// Ports:
//   clk, reset (sync, active-low)     -- pixel clock and reset
//   vsync                              -- raw vertical sync level; its rising edge is one frame tick
//   start_btn                          -- active-low button, asynchronous to clk
//   incscore                           -- one-clk brick-hit pulse
//   ball_lost                          -- level; sampled only on a frame tick
//   score1:score0                      -- BCD score, saturates at 99
//   lives, serve, play_en, game_over   -- game status
//   state                              -- IDLE=0, SERVE=1, PLAY=2, OVER=3
module game_state_ctrl #(
  parameter int START_LIVES  = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start_btn,
  input  logic       incscore,
  input  logic       ball_lost,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] lives,
  output logic       serve,
  output logic       play_en,
  output logic       game_over,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_FRAME = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] LIVES_INIT = 4'(START_LIVES);

  state_t     st;
  logic       btn_s1, btn_s2, btn_s3;  // 2-flop synchronizer plus one history flop for edge detect
  logic       vs_d1, vs_d2;
  logic [7:0] frame_cnt;
  logic       start;
  logic       frame_tick;
  logic       loss;

  // The button is active-low, so a press is a 1->0 edge on the synchronized level.
  assign start      = btn_s3 & ~btn_s2;
  assign frame_tick = vs_d1 & ~vs_d2;
  assign loss       = frame_tick & ball_lost;
  assign state      = st;

  // Two-digit BCD increment that sticks at 99 instead of wrapping.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] units);
    logic [7:0] r;
    if (tens == 4'd9 && units == 4'd9)
      r = {tens, units};
    else if (units == 4'd9)
      r = {tens + 4'd1, 4'd0};
    else
      r = {tens, units + 4'd1};
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= IDLE;
      score0    <= 4'd0;
      score1    <= 4'd0;
      lives     <= 4'd0;
      serve     <= 1'b0;
      play_en   <= 1'b0;
      game_over <= 1'b0;
      frame_cnt <= 8'd0;
      // The synchronizer idles at the released level, so a button held through reset
      // is only seen after it has crossed both flops.
      btn_s1    <= 1'b1;
      btn_s2    <= 1'b1;
      btn_s3    <= 1'b1;
      vs_d1     <= 1'b0;
      vs_d2     <= 1'b0;
    end else begin
      btn_s1 <= start_btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      vs_d1  <= vsync;
      vs_d2  <= vs_d1;
      serve  <= 1'b0;

      // Scoring runs independently of the state transitions below. A hit in the
      // same clk as a loss therefore still counts.
      if (incscore && (st == SERVE || st == PLAY))
        {score1, score0} <= bcd_inc(score1, score0);

      case (st)
        IDLE: begin
          if (start) begin
            st        <= SERVE;
            score0    <= 4'd0;
            score1    <= 4'd0;
            lives     <= LIVES_INIT;
            serve     <= 1'b1;
            frame_cnt <= 8'd0;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (frame_cnt == LAST_FRAME) begin
              st        <= PLAY;
              play_en   <= 1'b1;
              frame_cnt <= 8'd0;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        PLAY: begin
          if (loss) begin
            play_en <= 1'b0;
            if (lives <= 4'd1) begin
              // The last life is gone. Pin lives to zero so it cannot wrap.
              st        <= OVER;
              lives     <= 4'd0;
              game_over <= 1'b1;
            end else begin
              st        <= SERVE;
              lives     <= lives - 4'd1;
              serve     <= 1'b1;
              frame_cnt <= 8'd0;
            end
          end
        end
        OVER: begin
          // Return to IDLE only. The final score stays visible until the next game starts.
          if (start) begin
            st        <= IDLE;
            game_over <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Purpose: directed, self-checking bench for game_state_ctrl with default parameters.
// Latency: inputs change 1 time unit after a rising edge, and outputs are read at that same point.
// Backpressure: not applicable.
module tb_game_state_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vsync = 1'b0;
  logic       start_btn = 1'b1;
  logic       incscore = 1'b0;
  logic       ball_lost = 1'b0;
  logic [3:0] score0, score1, lives;
  logic       serve, play_en, game_over;
  logic [1:0] state;

  game_state_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .start_btn (start_btn),
    .incscore  (incscore),
    .ball_lost (ball_lost),
    .score0    (score0),
    .score1    (score1),
    .lives     (lives),
    .serve     (serve),
    .play_en   (play_en),
    .game_over (game_over),
    .state     (state)
  );

  always #5 clk = ~clk;

  int   passed = 0;
  int   total = 0;
  int   serve_cnt = 0;
  int   serve_dbl = 0;
  logic serve_prev = 1'b0;

  typedef struct {
    int   n_inc;     // incscore pulses to apply
    int   n_vs;      // vsync pulses to apply
    logic lost;      // ball_lost held during those vsync pulses
    int   e_state;
    int   e_s1;
    int   e_s0;
    int   e_lives;
    int   e_serves;  // serve pulses expected during the row
  } row_t;

  row_t rows[10];

  task automatic step();
    @(posedge clk);
    #1;
    if (serve) begin
      serve_cnt++;
      if (serve_prev) serve_dbl++;
    end
    serve_prev = serve;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic vpulse(input logic lost);
    ball_lost = lost;
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    step();
    ball_lost = 1'b0;
  endtask

  task automatic inc_pulse();
    incscore = 1'b1;
    step();
    incscore = 1'b0;
    step();
  endtask

  task automatic press();
    start_btn = 1'b0;
    repeat (6) step();
    start_btn = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    rows[0] = '{19, 0, 1'b0, 2, 1, 9, 3, 0};
    rows[1] = '{81, 0, 1'b0, 2, 9, 9, 3, 0};
    rows[2] = '{ 1, 0, 1'b0, 2, 9, 9, 3, 0};
    rows[3] = '{ 0, 1, 1'b0, 2, 9, 9, 3, 0};
    rows[4] = '{ 0, 1, 1'b1, 1, 9, 9, 2, 1};
    rows[5] = '{ 0, 60, 1'b0, 2, 9, 9, 2, 0};
    rows[6] = '{ 0, 1, 1'b1, 1, 9, 9, 1, 1};
    rows[7] = '{ 0, 60, 1'b0, 2, 9, 9, 1, 0};
    rows[8] = '{ 0, 1, 1'b1, 3, 9, 9, 0, 0};
    rows[9] = '{ 0, 1, 1'b1, 3, 9, 9, 0, 0};

    // Reset state
    repeat (3) step();
    chk("rst_state", state, 0);
    chk("rst_score0", score0, 0);
    chk("rst_score1", score1, 0);
    chk("rst_lives", lives, 0);
    chk("rst_serve", serve, 0);
    chk("rst_play_en", play_en, 0);
    chk("rst_game_over", game_over, 0);
    reset = 1'b1;
    step();

    // Start latency: the pin falls, then 3 clk later the game enters SERVE with one serve pulse.
    serve_cnt = 0;
    start_btn = 1'b0;
    step();
    step();
    chk("start_not_yet", state, 0);
    step();
    chk("start_state", state, 1);
    chk("start_serve", serve, 1);
    chk("start_lives", lives, 3);
    chk("start_score0", score0, 0);
    chk("start_score1", score1, 0);
    repeat (7) step();
    start_btn = 1'b1;
    repeat (4) step();
    chk("start_serve_count", serve_cnt, 1);

    // The serve hold lasts exactly 60 frames.
    repeat (59) vpulse(1'b0);
    chk("serve_59_state", state, 1);
    chk("serve_59_play_en", play_en, 0);
    vpulse(1'b0);
    chk("serve_60_state", state, 2);
    chk("serve_60_play_en", play_en, 1);

    // A start press during PLAY is ignored.
    press();
    chk("press_in_play", state, 2);

    // Table: score carry and saturation, then loss of all lives, then no underflow in OVER.
    for (int r = 0; r < 10; r++) begin
      serve_cnt = 0;
      for (int i = 0; i < rows[r].n_inc; i++) inc_pulse();
      for (int i = 0; i < rows[r].n_vs; i++) vpulse(rows[r].lost);
      chk($sformatf("row%0d_state", r), state, rows[r].e_state);
      chk($sformatf("row%0d_score1", r), score1, rows[r].e_s1);
      chk($sformatf("row%0d_score0", r), score0, rows[r].e_s0);
      chk($sformatf("row%0d_lives", r), lives, rows[r].e_lives);
      chk($sformatf("row%0d_serves", r), serve_cnt, rows[r].e_serves);
      chk($sformatf("row%0d_play_en", r), play_en, int'(rows[r].e_state == 2));
      chk($sformatf("row%0d_game_over", r), game_over, int'(rows[r].e_state == 3));
    end

    // A start press in OVER goes to IDLE and keeps the final score.
    press();
    chk("over_press_state", state, 0);
    chk("over_press_score1", score1, 9);
    chk("over_press_score0", score0, 9);
    chk("over_press_lives", lives, 0);
    chk("over_press_game_over", game_over, 0);

    // Second game. Scoring also counts during SERVE.
    serve_cnt = 0;
    press();
    chk("g2_state", state, 1);
    chk("g2_lives", lives, 3);
    chk("g2_score0", score0, 0);
    chk("g2_serve_count", serve_cnt, 1);
    inc_pulse();
    inc_pulse();
    chk("g2_serve_score0", score0, 2);
    repeat (60) vpulse(1'b0);
    chk("g2_play", state, 2);

    // A hit and a loss land in the same clk.
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    incscore = 1'b1;
    ball_lost = 1'b1;
    step();
    incscore = 1'b0;
    ball_lost = 1'b0;
    chk("simul_score0", score0, 3);
    chk("simul_score1", score1, 0);
    chk("simul_lives", lives, 2);
    chk("simul_state", state, 1);
    chk("simul_serve", serve, 1);
    step();

    repeat (60) vpulse(1'b0);
    chk("g2_play2", state, 2);
    repeat (39) inc_pulse();
    chk("g2_score1", score1, 4);
    chk("g2_score0", score0, 2);

    // Reset in the middle of PLAY.
    reset = 1'b0;
    step();
    chk("midrst_state", state, 0);
    chk("midrst_score0", score0, 0);
    chk("midrst_score1", score1, 0);
    chk("midrst_lives", lives, 0);
    chk("midrst_serve", serve, 0);
    chk("midrst_play_en", play_en, 0);
    chk("midrst_game_over", game_over, 0);
    step();
    reset = 1'b1;
    serve_cnt = 0;
    repeat (5) step();
    chk("rst_release_no_serve", serve_cnt, 0);
    chk("rst_release_state", state, 0);

    chk("serve_never_double", serve_dbl, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter START_LIVES, default 3, meaning lives loaded at game start (range 1..9).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, meaning frames the ball is held before each serve (range 1..255).
REQ-003 SHALL have port clk  input  1  pixel clock, the only clock.
REQ-004 SHALL have port reset  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port vsync  input  1  raw vertical sync level, active-high, synchronous to clk.
REQ-006 SHALL have port start_btn  input  1  start button, active-low, asynchronous to clk.
REQ-007 SHALL have port incscore  input  1  one-clk brick-hit pulse.
REQ-008 SHALL have port ball_lost  input  1  level, high while the ball is below the paddle row.
REQ-009 SHALL have port score0  output  4  BCD score, units digit.
REQ-010 SHALL have port score1  output  4  BCD score, tens digit.
REQ-011 SHALL have port lives  output  4  lives remaining, binary.
REQ-012 SHALL have port serve  output  1  one-clk pulse that recentres the ball.
REQ-013 SHALL have port play_en  output  1  high only in PLAY; gates ball motion.
REQ-014 SHALL have port game_over  output  1  high only in OVER.
REQ-015 SHALL have port state  output  2  FSM state encoding: IDLE=0, SERVE=1, PLAY=2, OVER=3.

Function
REQ-016 SHALL pass start_btn through a 2-flop synchronizer; start = falling edge of the synchronized signal (one-clk pulse, 3 clk latency from pin).
REQ-017 SHALL generate frame_tick = one-clk pulse on each vsync rising edge (registered edge detect, 1 clk latency).
REQ-018 SHALL sample ball_lost only on frame_tick; a loss = ball_lost high at that tick.
REQ-019 IDLE -> SERVE on start; on that edge: score0 = 0, score1 = 0, lives = START_LIVES, serve pulses in the same clk as the transition.
REQ-020 SERVE: 8-bit frame counter cleared on entry, incremented per frame_tick; -> PLAY on the tick where the count reaches SERVE_FRAMES-1 (exactly SERVE_FRAMES ticks spent in SERVE).
REQ-021 PLAY: on loss, lives decrements by 1; if lives was 1 -> OVER, else -> SERVE with a serve pulse.
REQ-022 OVER -> IDLE on start; score and lives held until then; start in OVER SHALL NOT begin a new game directly.
REQ-023 Start pulses in SERVE and PLAY SHALL be ignored.
REQ-024 incscore SHALL count only in SERVE or PLAY; BCD increment: score0 wraps 9->0 with a carry into score1; 99 saturates (no wrap to 00).
REQ-025 An incscore and a loss in the same clk SHALL both take effect (score +1, lives -1).
REQ-026 serve SHALL never be high for more than one consecutive clk.
REQ-027 lives SHALL never underflow below 0; the OVER state holds lives = 0.
REQ-028 Outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-029 While reset = 0 at a rising clk edge: state = IDLE, score0 = 0, score1 = 0, lives = 0, serve = 0, play_en = 0, game_over = 0, frame counter = 0, synchronizer flops = 1, edge-detect flops = 0.
REQ-030 Reset SHALL override every event in the same clk, including a reset asserted mid-SERVE or mid-PLAY; no serve pulse is issued on reset release.
REQ-031 The first start pulse SHALL be recognised no earlier than 3 clk after reset release.

Verification
REQ-032 Start from reset: drop start_btn for 10 clk -> state 1, lives 3, score 00, one serve pulse; after exactly 60 vsync rises -> state 2, play_en = 1.
REQ-033 Score carry: in PLAY, 19 incscore pulses -> score1 = 1, score0 = 9; 81 more -> 99; one more -> still 99.
REQ-034 Lives: in PLAY, hold ball_lost across one vsync rise -> lives 2, state 1, serve pulse; repeat twice more -> lives 0, state 3, game_over = 1.
REQ-035 Simultaneous events: incscore and a frame_tick with ball_lost in the same clk -> score +1 and lives -1 together.
REQ-036 Ignored start: a press in PLAY -> no state change; a press in OVER -> IDLE, with score still held.
REQ-037 Mid-game reset: assert reset in PLAY with score 42 -> next clk: all outputs 0, state 0.
